// File: rtl/mips16_pkg.sv
// Shared constants and types for the MIPS16 pipeline interrupt controller.
//   PC_W         : program-counter width
//   INT_VECTOR   : handler entry address loaded on interrupt acknowledge
//   DRAIN_CYCLES : cycles spent flushing the front end before vectoring
//   int_state_e  : interrupt controller FSM encoding
//   int_ctrl_t   : bundle of one-bit pipeline control outputs
package mips16_pkg;

  localparam int unsigned PC_W         = 16;
  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned DRAIN_CNT_W  = 2;

  localparam logic [PC_W-1:0] INT_VECTOR = 16'h0040;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RETURN  = 3'd4
  } int_state_e;

  typedef struct packed {
    logic stall_pc;
    logic flush_if_id;
    logic flush_id_ex;
    logic pc_load;
    logic int_active;
    logic int_ack;
  } int_ctrl_t;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector and sticky pending flag for the external interrupt.
//   clk, reset   : clock, synchronous active-low reset
//   i_interrupt  : raw interrupt request level
//   i_clr        : acknowledge; clears pending
//   o_pending    : an edge has been seen and not yet acknowledged
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic i_interrupt,
  input  logic i_clr,
  output logic o_pending
);

  logic r_hist;
  logic r_pending;
  logic w_edge;

  // History resets low so a request already high after reset counts as an edge.
  assign w_edge = i_interrupt & ~r_hist;

  // A new edge on the acknowledge cycle wins so the request is not lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_hist <= i_interrupt;
      if (w_edge) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/pipeline_int_ctrl.sv
// Pipeline interrupt controller: drains the front end, vectors to the handler,
// and restores the interrupted PC on return-from-interrupt.
//   clk, reset                  : clock, synchronous active-low reset
//   interrupt                   : external request (rising edge is the event)
//   ei_dec, di_dec, reti_dec    : decode-stage enable/disable/return pulses
//   branch_pending              : unresolved control transfer; defers entry
//   resume_pc                   : PC of the instruction in ID
//   stall_pc, flush_if_id,
//   flush_id_ex                 : pipeline hold/kill controls
//   pc_load, pc_next            : PC override strobe and target
//   epc                         : saved return address
//   int_active, int_ack, ie     : in-handler flag, acknowledge, enable flag
module pipeline_int_ctrl
  import mips16_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            interrupt,
  input  logic            ei_dec,
  input  logic            di_dec,
  input  logic            reti_dec,
  input  logic            branch_pending,
  input  logic [PC_W-1:0] resume_pc,
  output logic            stall_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] epc,
  output logic            int_active,
  output logic            int_ack,
  output logic            ie
);

  int_state_e             r_state;
  int_state_e             w_state_nxt;
  logic [DRAIN_CNT_W-1:0] r_cnt;
  logic [DRAIN_CNT_W-1:0] w_cnt_nxt;
  logic                   r_ie;
  logic                   w_ie_nxt;
  logic [PC_W-1:0]        r_epc;
  logic [PC_W-1:0]        w_epc_nxt;
  int_ctrl_t              r_ctrl;
  int_ctrl_t              w_ctrl_nxt;
  logic [PC_W-1:0]        r_pc_next;
  logic [PC_W-1:0]        w_pc_next_nxt;
  logic                   w_pending;
  logic                   w_ack_c;

  // Pending is consumed on the cycle the acknowledge is presented.
  assign w_ack_c = (r_state == ST_VECTOR);

  int_edge_latch u_edge (
    .clk         (clk),
    .reset       (reset),
    .i_interrupt (interrupt),
    .i_clr       (w_ack_c),
    .o_pending   (w_pending)
  );

  // State, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ie      <= 1'b0;
      r_epc     <= '0;
      r_ctrl    <= '0;
      r_pc_next <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ie      <= w_ie_nxt;
      r_epc     <= w_epc_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_pc_next <= w_pc_next_nxt;
    end
  end

  // Next state, flag updates, and outputs decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ie_nxt      = r_ie;
    w_epc_nxt     = r_epc;
    w_ctrl_nxt    = '0;
    w_pc_next_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        if (di_dec) begin
          w_ie_nxt = 1'b0;
        end else if (ei_dec) begin
          w_ie_nxt = 1'b1;
        end
        if (w_pending && r_ie && !di_dec && !branch_pending) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
          w_epc_nxt   = resume_pc;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_VECTOR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + DRAIN_CNT_W'(1);
        end
      end
      ST_VECTOR: begin
        w_ie_nxt    = 1'b0;
        w_state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti_dec) begin
          w_state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: begin
        w_ie_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    case (w_state_nxt)
      ST_DRAIN: begin
        w_ctrl_nxt.stall_pc    = 1'b1;
        w_ctrl_nxt.flush_if_id = 1'b1;
        w_ctrl_nxt.flush_id_ex = 1'b1;
      end
      ST_VECTOR: begin
        w_ctrl_nxt.pc_load = 1'b1;
        w_ctrl_nxt.int_ack = 1'b1;
        w_pc_next_nxt      = INT_VECTOR;
      end
      ST_SERVICE: begin
        w_ctrl_nxt.int_active = 1'b1;
      end
      ST_RETURN: begin
        w_ctrl_nxt.pc_load     = 1'b1;
        w_ctrl_nxt.flush_if_id = 1'b1;
        w_ctrl_nxt.int_active  = 1'b1;
        w_pc_next_nxt          = w_epc_nxt;
      end
      default: begin
      end
    endcase
  end

  assign stall_pc    = r_ctrl.stall_pc;
  assign flush_if_id = r_ctrl.flush_if_id;
  assign flush_id_ex = r_ctrl.flush_id_ex;
  assign pc_load     = r_ctrl.pc_load;
  assign int_active  = r_ctrl.int_active;
  assign int_ack     = r_ctrl.int_ack;
  assign pc_next     = r_pc_next;
  assign epc         = r_epc;
  assign ie          = r_ie;

endmodule

// File: tb/tb_pipeline_int_ctrl.sv
// Directed bench for pipeline_int_ctrl. Each step drives inputs, pushes the
// outputs expected after the next rising edge, then pops and compares them.
module tb_pipeline_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic        ei_dec;
  logic        di_dec;
  logic        reti_dec;
  logic        branch_pending;
  logic [15:0] resume_pc;
  logic        stall_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        pc_load;
  logic [15:0] pc_next;
  logic [15:0] epc;
  logic        int_active;
  logic        int_ack;
  logic        ie;

  typedef enum int {PH_IDLE, PH_DRAIN, PH_VECTOR, PH_SERVICE, PH_RETURN} phase_e;

  typedef struct {
    string       tag;
    logic        stall;
    logic        fif;
    logic        fie;
    logic        load;
    logic        act;
    logic        ack;
    logic        ie;
    logic [15:0] pcn;
    logic [15:0] epc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        exp_ie;
  logic [15:0] exp_epc;

  always #5 clk = ~clk;

  pipeline_int_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .interrupt      (interrupt),
    .ei_dec         (ei_dec),
    .di_dec         (di_dec),
    .reti_dec       (reti_dec),
    .branch_pending (branch_pending),
    .resume_pc      (resume_pc),
    .stall_pc       (stall_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .epc            (epc),
    .int_active     (int_active),
    .int_ack        (int_ack),
    .ie             (ie)
  );

  task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  // Expected outputs for each controller phase, straight from the output table.
  task automatic push(input string tag, input phase_e ph);
    exp_t e;
    e.tag = tag;
    e.stall = 1'b0; e.fif = 1'b0; e.fie = 1'b0; e.load = 1'b0;
    e.act = 1'b0; e.ack = 1'b0; e.pcn = 16'h0000;
    e.ie = exp_ie; e.epc = exp_epc;
    case (ph)
      PH_DRAIN:   begin e.stall = 1'b1; e.fif = 1'b1; e.fie = 1'b1; end
      PH_VECTOR:  begin e.load = 1'b1; e.ack = 1'b1; e.pcn = 16'h0040; end
      PH_SERVICE: begin e.act = 1'b1; end
      PH_RETURN:  begin e.load = 1'b1; e.fif = 1'b1; e.act = 1'b1; e.pcn = exp_epc; end
      default:    begin end
    endcase
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "stall_pc",    16'(stall_pc),    16'(e.stall));
      chk(e.tag, "flush_if_id", 16'(flush_if_id), 16'(e.fif));
      chk(e.tag, "flush_id_ex", 16'(flush_id_ex), 16'(e.fie));
      chk(e.tag, "pc_load",     16'(pc_load),     16'(e.load));
      chk(e.tag, "pc_next",     pc_next,          e.pcn);
      chk(e.tag, "int_active",  16'(int_active),  16'(e.act));
      chk(e.tag, "int_ack",     16'(int_ack),     16'(e.ack));
      chk(e.tag, "ie",          16'(ie),          16'(e.ie));
      chk(e.tag, "epc",         epc,              e.epc);
    end
  endtask

  task automatic cyc(input string tag, input phase_e ph);
    push(tag, ph);
    tick();
  endtask

  initial begin
    reset = 1'b0; interrupt = 1'b0; ei_dec = 1'b0; di_dec = 1'b0;
    reti_dec = 1'b0; branch_pending = 1'b0; resume_pc = 16'h0100;
    exp_ie = 1'b0; exp_epc = 16'h0000;

    // Reset held low for two cycles.
    cyc("rst_a", PH_IDLE);
    cyc("rst_b", PH_IDLE);
    reset = 1'b1;

    // Interrupt with ie=0: pending held, no entry; stray reti ignored.
    interrupt = 1'b1; cyc("ie0_edge", PH_IDLE); interrupt = 1'b0;
    cyc("ie0_hold1", PH_IDLE);
    cyc("ie0_hold2", PH_IDLE);
    reti_dec = 1'b1; cyc("reti_idle", PH_IDLE); reti_dec = 1'b0;
    ei_dec = 1'b1; exp_ie = 1'b1; cyc("ei_set", PH_IDLE); ei_dec = 1'b0;
    exp_epc = 16'h0100;
    cyc("lat_d1", PH_DRAIN);
    cyc("lat_d2", PH_DRAIN);
    cyc("lat_d3", PH_DRAIN);
    cyc("lat_ack", PH_VECTOR);
    exp_ie = 1'b0;
    cyc("lat_svc0", PH_SERVICE);
    cyc("lat_svc1", PH_SERVICE);
    reti_dec = 1'b1; cyc("lat_ret", PH_RETURN); reti_dec = 1'b0;
    exp_ie = 1'b1;
    cyc("lat_idle", PH_IDLE);

    // Normal entry with resume_pc 0x0012.
    resume_pc = 16'h0012;
    interrupt = 1'b1; cyc("e27_edge", PH_IDLE); interrupt = 1'b0;
    exp_epc = 16'h0012;
    cyc("e27_d1", PH_DRAIN);
    resume_pc = 16'h0034;
    cyc("e27_d2", PH_DRAIN);
    cyc("e27_d3", PH_DRAIN);
    cyc("e27_vec", PH_VECTOR);
    exp_ie = 1'b0;
    cyc("e27_svc", PH_SERVICE);

    // Edge inside the handler does not preempt; taken again after return.
    interrupt = 1'b1; cyc("e28_edge_svc", PH_SERVICE); interrupt = 1'b0;
    cyc("e28_svc1", PH_SERVICE);
    cyc("e28_svc2", PH_SERVICE);
    reti_dec = 1'b1; cyc("e28_ret", PH_RETURN); reti_dec = 1'b0;
    exp_ie = 1'b1;
    cyc("e28_idle", PH_IDLE);
    exp_epc = 16'h0034;
    cyc("e28_redrain1", PH_DRAIN);
    cyc("e28_redrain2", PH_DRAIN);
    cyc("e28_redrain3", PH_DRAIN);
    cyc("e28_vec", PH_VECTOR);
    exp_ie = 1'b0;
    cyc("e28_svc3", PH_SERVICE);
    reti_dec = 1'b1; cyc("e28_ret2", PH_RETURN); reti_dec = 1'b0;
    exp_ie = 1'b1;
    cyc("e28_idle2", PH_IDLE);
    cyc("e28_idle3", PH_IDLE);

    // Branch pending for four cycles defers entry.
    resume_pc = 16'h0056; branch_pending = 1'b1;
    interrupt = 1'b1; cyc("e29_b0", PH_IDLE); interrupt = 1'b0;
    cyc("e29_b1", PH_IDLE);
    cyc("e29_b2", PH_IDLE);
    cyc("e29_b3", PH_IDLE);
    branch_pending = 1'b0;
    exp_epc = 16'h0056;
    cyc("e29_d1", PH_DRAIN);
    cyc("e29_d2", PH_DRAIN);
    cyc("e29_d3", PH_DRAIN);
    cyc("e29_vec", PH_VECTOR);
    exp_ie = 1'b0;
    cyc("e29_svc", PH_SERVICE);
    reti_dec = 1'b1; cyc("e29_ret", PH_RETURN); reti_dec = 1'b0;
    exp_ie = 1'b1;
    cyc("e29_idle", PH_IDLE);

    // Reset during the second drain cycle.
    resume_pc = 16'h0078;
    interrupt = 1'b1; cyc("e30_edge", PH_IDLE); interrupt = 1'b0;
    exp_epc = 16'h0078;
    cyc("e30_d1", PH_DRAIN);
    cyc("e30_d2", PH_DRAIN);
    reset = 1'b0; exp_ie = 1'b0; exp_epc = 16'h0000;
    cyc("e30_rst", PH_IDLE);
    reset = 1'b1;
    ei_dec = 1'b1; exp_ie = 1'b1; cyc("e30_ei", PH_IDLE); ei_dec = 1'b0;
    cyc("e30_nopend1", PH_IDLE);
    cyc("e30_nopend2", PH_IDLE);

    // ei and di together: di wins; di also blocks entry in its cycle.
    interrupt = 1'b1; ei_dec = 1'b1; di_dec = 1'b1; exp_ie = 1'b0;
    cyc("e31_both", PH_IDLE);
    interrupt = 1'b0; ei_dec = 1'b0; di_dec = 1'b0;
    cyc("e31_hold1", PH_IDLE);
    cyc("e31_hold2", PH_IDLE);
    ei_dec = 1'b1; exp_ie = 1'b1; cyc("e31_ei", PH_IDLE); ei_dec = 1'b0;
    di_dec = 1'b1; exp_ie = 1'b0; cyc("e31_di_block", PH_IDLE); di_dec = 1'b0;
    cyc("e31_hold3", PH_IDLE);

    // Request already high at reset release counts as an edge.
    reset = 1'b0; interrupt = 1'b1;
    cyc("e23_rst", PH_IDLE);
    reset = 1'b1;
    ei_dec = 1'b1; exp_ie = 1'b1; cyc("e23_first", PH_IDLE); ei_dec = 1'b0;
    resume_pc = 16'h009a; exp_epc = 16'h009a;
    cyc("e23_d1", PH_DRAIN);
    cyc("e23_d2", PH_DRAIN);
    cyc("e23_d3", PH_DRAIN);
    cyc("e23_vec", PH_VECTOR);
    exp_ie = 1'b0;
    cyc("e23_svc", PH_SERVICE);
    interrupt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
